// File: rtl/wave_index_gen_if.sv
// Pixel/frame timing inputs and ROM index outputs of wave_index_gen.
// The master drives the timing strobes and target frequency; the slave is the generator.
interface wave_index_gen_if;
    logic        frame_start;
    logic        line_start;
    logic        pixel_en;
    logic [10:0] target_freq;
    logic [10:0] index;
    logic        index_valid;
    logic [10:0] cur_freq;
    logic [9:0]  phase;

    modport master (
        output frame_start, line_start, pixel_en, target_freq,
        input  index, index_valid, cur_freq, phase
    );

    modport slave (
        input  frame_start, line_start, pixel_en, target_freq,
        output index, index_valid, cur_freq, phase
    );
endinterface

// File: rtl/wave_index_gen.sv
// Per-pixel phase index generator for the sine ROM: per-frame scroll and frequency glide,
// per-line fixed-point (10.8) phase accumulation.
module wave_index_gen #(
    parameter int unsigned SCROLL_STEP = 4,
    parameter int unsigned GLIDE_STEP  = 2
) (
    input logic             clk,
    input logic             rst_n,
    wave_index_gen_if.slave bus
);
    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [9:0]  ScrollInc = 10'(SCROLL_STEP);
    localparam logic [10:0] GlideInc  = 11'(GLIDE_STEP);

    state_e      state_q, state_d;
    logic [9:0]  phase_q, phase_d;
    logic [10:0] cur_freq_q, cur_freq_d;
    logic [17:0] acc_q, acc_d;
    logic [10:0] index_q, index_d;
    logic        index_valid_q, index_valid_d;
    logic [17:0] base;
    logic [10:0] diff;
    logic        run;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cur_freq_d    = cur_freq_q;
        acc_d         = acc_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        base          = acc_q;
        diff          = '0;
        run           = (state_q == StRun);

        if (bus.frame_start) begin
            state_d = StRun;
            phase_d = phase_q + ScrollInc;
            if (bus.target_freq != 11'd0) begin
                if (bus.target_freq >= cur_freq_q) begin
                    diff       = bus.target_freq - cur_freq_q;
                    cur_freq_d = (diff <= GlideInc) ? bus.target_freq : cur_freq_q + GlideInc;
                end else begin
                    diff       = cur_freq_q - bus.target_freq;
                    cur_freq_d = (diff <= GlideInc) ? bus.target_freq : cur_freq_q - GlideInc;
                end
            end
        end

        // phase_d/cur_freq_d already carry the frame update when it coincides
        if (run && bus.line_start) begin
            base  = {phase_d, 8'b0};
            acc_d = base;
        end

        if (run && bus.pixel_en) begin
            index_d       = {1'b0, base[17:8]};
            index_valid_d = 1'b1;
            acc_d         = base + {7'b0, cur_freq_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            cur_freq_q    <= 11'd256;
            acc_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cur_freq_q    <= cur_freq_d;
            acc_q         <= acc_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
        end
    end

    assign bus.index       = index_q;
    assign bus.index_valid = index_valid_q;
    assign bus.cur_freq    = cur_freq_q;
    assign bus.phase       = phase_q;
endmodule
